// File: rtl/fetch_unit.sv
// IF stage of the rv32 pipeline: PC register, single-outstanding instruction fetch
// over a req/gnt/rvalid port, and the IF/ID pipeline register with redirect/stall handling.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSel_EX,
  input  logic [31:0] target_EX,
  input  logic        stall_ID,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        valid_ID,
  output logic [31:0] inst_ID,
  output logic [31:0] pc_ID,
  output logic [31:0] pc4_ID
);
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DRAIN} state_t;

  state_t      state, state_d;
  logic [31:0] pc_q, pc_d, pc_fl, pc_fl_d;
  logic [31:0] hold_inst, hold_inst_d, hold_pc, hold_pc_d;
  logic        load;
  logic [31:0] load_inst, load_pc;
  logic        busy;

  assign imem_req  = rst_n && (state == S_REQ);
  assign imem_addr = pc_q;

  // A response will still arrive after this edge, so a redirect must drain it.
  assign busy = ((state == S_REQ) && imem_gnt) ||
                (((state == S_WAIT) || (state == S_DRAIN)) && !imem_rvalid);

  always_comb begin
    state_d     = state;
    pc_d        = pc_q;
    pc_fl_d     = pc_fl;
    hold_inst_d = hold_inst;
    hold_pc_d   = hold_pc;
    load        = 1'b0;
    load_inst   = hold_inst;
    load_pc     = hold_pc;
    case (state)
      S_REQ: if (imem_gnt) begin
        pc_fl_d = pc_q;
        pc_d    = pc_q + 32'd4;
        state_d = S_WAIT;
      end
      S_WAIT: if (imem_rvalid) begin
        if (stall_ID) begin
          hold_inst_d = imem_rdata;
          hold_pc_d   = pc_fl;
          state_d     = S_HOLD;
        end else begin
          load      = 1'b1;
          load_inst = imem_rdata;
          load_pc   = pc_fl;
          state_d   = S_REQ;
        end
      end
      S_HOLD: if (!stall_ID) begin
        load    = 1'b1;
        state_d = S_REQ;
      end
      S_DRAIN: if (imem_rvalid) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
    // Redirect overrides everything: new PC, drop held data, drain any owed response.
    if (PCSel_EX) begin
      pc_d        = target_EX & ~32'd3;
      state_d     = busy ? S_DRAIN : S_REQ;
      hold_inst_d = '0;
      hold_pc_d   = '0;
      load        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_REQ;
      pc_q      <= RESET_PC;
      pc_fl     <= '0;
      hold_inst <= '0;
      hold_pc   <= '0;
    end else begin
      state     <= state_d;
      pc_q      <= pc_d;
      pc_fl     <= pc_fl_d;
      hold_inst <= hold_inst_d;
      hold_pc   <= hold_pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_ID <= 1'b0;
      inst_ID  <= NOP_INST;
      pc_ID    <= '0;
      pc4_ID   <= '0;
    end else if (PCSel_EX) begin
      valid_ID <= 1'b0;
      inst_ID  <= NOP_INST;
      pc_ID    <= '0;
      pc4_ID   <= '0;
    end else if (load) begin
      valid_ID <= 1'b1;
      inst_ID  <= load_inst;
      pc_ID    <= load_pc;
      pc4_ID   <= load_pc + 32'd4;
    end else if (!stall_ID) begin
      valid_ID <= 1'b0;
      inst_ID  <= NOP_INST;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: memory responder plus an instruction-stream reference model
// (next expected fetch address and next expected delivered PC), directed and random steps.
module tb_fetch_unit;
  localparam logic [31:0] RST_PC = 32'hFFFF_FFFC;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0, rst_n = 1'b1;
  logic        PCSel_EX = 1'b0, stall_ID = 1'b0, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] target_EX = '0, imem_rdata = '0;
  logic        imem_req, valid_ID;
  logic [31:0] imem_addr, inst_ID, pc_ID, pc4_ID;

  fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .PCSel_EX(PCSel_EX), .target_EX(target_EX),
    .stall_ID(stall_ID), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .valid_ID(valid_ID), .inst_ID(inst_ID), .pc_ID(pc_ID), .pc4_ID(pc4_ID)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  logic [31:0] exp_pc, exp_fetch;   // next PC ID should consume, next address to fetch
  int          delivered = 0;
  bit          pend = 0, stale = 0, rand_mode = 0;
  logic [31:0] pend_addr = '0;
  int          pend_cnt = 0, fixed_delay = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check before the edge, advance the model at the edge, drive the responder at negedge.
  task automatic tick();
    logic s_rst, s_pcsel, s_req, s_gnt, s_rv, consume;
    logic [31:0] s_tgt, s_addr;
    s_rst = rst_n; s_pcsel = PCSel_EX; s_req = imem_req; s_gnt = imem_gnt;
    s_rv = imem_rvalid; s_tgt = target_EX; s_addr = imem_addr; consume = 1'b0;
    if (rst_n) begin
      if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
      if (pend && !stale) chk("one_outstanding", 32'(imem_req), 32'd0);
      if (!valid_ID) chk("bubble_nop", inst_ID, NOP);
      consume = valid_ID && !stall_ID && !PCSel_EX;
      if (consume) begin
        chk("pc_ID", pc_ID, exp_pc);
        chk("inst_ID", inst_ID, memf(exp_pc));
        chk("pc4_ID", pc4_ID, exp_pc + 32'd4);
      end
    end
    @(posedge clk);
    if (s_rst) begin
      if (consume) begin exp_pc = exp_pc + 32'd4; delivered++; end
      if (s_pcsel) begin
        exp_pc    = s_tgt & ~32'd3;
        exp_fetch = s_tgt & ~32'd3;
      end else if (s_req && s_gnt) exp_fetch = exp_fetch + 32'd4;
      if (s_rv) begin pend = 0; stale = 0; end
      if (s_req && s_gnt) begin
        pend = 1; pend_addr = s_addr;
        pend_cnt = rand_mode ? int'($urandom_range(0, 3)) : fixed_delay;
      end
    end
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (rst_n && pend) begin
      if (pend_cnt == 0) begin imem_rvalid = 1'b1; imem_rdata = memf(pend_addr); end
      else pend_cnt--;
    end
    imem_gnt = !stale && (!rand_mode || ($urandom_range(0, 2) != 0));
    #1;
  endtask

  task automatic do_reset(input int cycles, input bit chk_async);
    rst_n = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0; PCSel_EX = 1'b0; stall_ID = 1'b0;
    stale = pend;
    #1;
    if (chk_async) begin
      chk("async_valid", 32'(valid_ID), 32'd0);
      chk("async_inst", inst_ID, NOP);
      chk("async_pc", pc_ID, 32'd0);
      chk("async_pc4", pc4_ID, 32'd0);
      chk("async_req", 32'(imem_req), 32'd0);
    end
    exp_pc = RST_PC; exp_fetch = RST_PC;
    repeat (cycles) tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(valid_ID), 32'd0);
    chk("rst_inst", inst_ID, NOP);
    chk("rst_pc", pc_ID, 32'd0);
    chk("rst_pc4", pc4_ID, 32'd0);
    rst_n = 1'b1; imem_gnt = !stale;
    #1;
    chk("rel_req", 32'(imem_req), 32'd1);
    chk("rel_addr", imem_addr, RST_PC);
  endtask

  // Tick until a fresh (non-stale) fetch is outstanding; optionally require its data not yet returned.
  task automatic wait_pend(input bit no_rv, input string tag);
    bit ok = 0;
    for (int i = 0; i < 20; i++) begin
      if (pend && !stale && !(no_rv && imem_rvalid)) begin ok = 1; break; end
      tick();
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  task automatic wait_valid(input string tag, input logic [31:0] pc);
    bit ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (valid_ID) begin ok = 1; break; end
      tick();
    end
    chk({tag, "_seen"}, 32'(ok), 32'd1);
    chk({tag, "_pc"}, pc_ID, pc);
    chk({tag, "_inst"}, inst_ID, memf(pc));
  endtask

  logic        snap_v, held_ok, t6_ok;
  logic [31:0] snap_i, snap_p, snap_p4, held_pc;
  int          base;

  initial begin
    // Reset, then 1-cycle gnt/rvalid streaming across the PC wrap
    fixed_delay = 0;
    do_reset(2, 1'b0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("t1_valid", 32'(valid_ID), 32'((k % 2) == 0));
      if ((k % 2) == 0) begin
        chk("t1_pc", pc_ID, RST_PC + 32'(4 * (k / 2 - 1)));
        chk("t1_pc4", pc4_ID, RST_PC + 32'(4 * (k / 2)));
      end
    end

    // Redirect while waiting: owed response discarded, fetch resumes at aligned target
    fixed_delay = 2;
    wait_pend(1'b1, "t2_reach_wait");
    PCSel_EX = 1'b1; target_EX = 32'h0000_0102;
    tick();
    PCSel_EX = 1'b0;
    chk("t2_flush_valid", 32'(valid_ID), 32'd0);
    chk("t2_flush_inst", inst_ID, NOP);
    chk("t2_flush_pc", pc_ID, 32'd0);
    chk("t2_flush_pc4", pc4_ID, 32'd0);
    chk("t2_drain_noreq", 32'(imem_req), 32'd0);
    for (int i = 0; i < 10 && !imem_req; i++) tick();
    chk("t2_new_addr", imem_addr, 32'h0000_0100);
    wait_valid("t2_first", 32'h0000_0100);

    // Stall across rvalid: IF/ID frozen, no new request, held instruction lands after stall
    fixed_delay = 1;
    wait_pend(1'b1, "t3_reach_wait");
    held_pc = pend_addr;
    snap_v = valid_ID; snap_i = inst_ID; snap_p = pc_ID; snap_p4 = pc4_ID;
    stall_ID = 1'b1;
    repeat (3) begin
      tick();
      chk("t3_hold_valid", 32'(valid_ID), 32'(snap_v));
      chk("t3_hold_inst", inst_ID, snap_i);
      chk("t3_hold_pc", pc_ID, snap_p);
      chk("t3_hold_pc4", pc4_ID, snap_p4);
      chk("t3_noreq", 32'(imem_req), 32'd0);
    end
    stall_ID = 1'b0;
    tick();
    held_ok = valid_ID;
    chk("t3_held_valid", 32'(held_ok), 32'd1);
    chk("t3_held_pc", pc_ID, held_pc);
    chk("t3_held_inst", inst_ID, memf(held_pc));
    chk("t3_req_resume", 32'(imem_req), 32'd1);

    // Redirect and stall together while holding: flush wins, held instruction lost
    fixed_delay = 0;
    wait_pend(1'b0, "t4_reach_wait");
    stall_ID = 1'b1;
    tick();
    chk("t4_in_hold_noreq", 32'(imem_req), 32'd0);
    PCSel_EX = 1'b1; target_EX = 32'h0000_0200;
    tick();
    PCSel_EX = 1'b0; stall_ID = 1'b0;
    chk("t4_flush_valid", 32'(valid_ID), 32'd0);
    chk("t4_flush_inst", inst_ID, NOP);
    chk("t4_flush_pc", pc_ID, 32'd0);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h0000_0200);
    wait_valid("t4_first", 32'h0000_0200);

    // Reset mid-fetch: async clear, stale rvalid after release must be ignored
    fixed_delay = 2;
    wait_pend(1'b1, "t6_reach_wait");
    do_reset(2, 1'b1);
    t6_ok = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (!stale) begin t6_ok = 1'b1; break; end
      tick();
    end
    chk("t6_stale_seen", 32'(t6_ok), 32'd1);
    chk("t6_stale_ignored", 32'(valid_ID), 32'd0);
    wait_valid("t6_first", RST_PC);

    // Random traffic: random grant/latency, stalls and redirects against the stream model
    rand_mode = 1;
    base = delivered;
    for (int i = 0; i < 1500; i++) begin
      stall_ID  = ($urandom_range(0, 9) < 3);
      PCSel_EX  = ($urandom_range(0, 24) == 0);
      target_EX = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : 32'($urandom_range(0, 1023));
      tick();
    end
    PCSel_EX = 1'b0; stall_ID = 1'b0;
    chk("rand_progress", 32'((delivered - base) >= 50), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
